// File: rtl/ospfb_frame_capture.sv
// ospfb_frame_capture: AXI-Stream sink that aligns to OSPFB frame boundaries
// with tlast and captures NFRAMES consecutive FFT_LEN-bin frames into a RAM.
// The RAM can be read through a registered read port. The block also flags
// frames of the wrong length and counts beats it drops while the buffer is full.
module ospfb_frame_capture #(
    parameter int WIDTH   = 16,
    parameter int FFT_LEN = 64,
    parameter int NFRAMES = 4,
    localparam int AW     = $clog2(FFT_LEN * NFRAMES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*WIDTH-1:0]   s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 arm,
    input  logic [AW-1:0]        rd_addr,
    output logic [2*WIDTH-1:0]   rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 len_err,
    output logic [15:0]          drop_cnt
);

    localparam int BW    = $clog2(FFT_LEN);
    localparam int FW    = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
    localparam int DEPTH = FFT_LEN * NFRAMES;
    localparam logic [BW-1:0] BIN_LAST   = BW'(FFT_LEN - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(NFRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ALIGN   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FULL    = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [BW-1:0]       bin_r;
    logic [BW-1:0]       bin_nxt_s;
    logic [FW-1:0]       frame_r;
    logic [FW-1:0]       frame_nxt_s;
    logic                len_err_r;
    logic                len_err_nxt_s;
    logic [15:0]         drop_cnt_r;
    logic [15:0]         drop_cnt_nxt_s;
    logic                tready_r;
    logic                busy_r;
    logic                done_r;
    logic [2*WIDTH-1:0]  rd_data_r;
    logic                wr_en_s;
    logic                beat_s;
    logic [AW-1:0]       wr_addr_s;

    logic [2*WIDTH-1:0]  mem [0:DEPTH-1];

    // tready is only ever low in IDLE, so a beat is simply valid while ready.
    assign beat_s    = s_axis_tvalid && tready_r;
    // frame*FFT_LEN+bin is a plain concatenation because FFT_LEN is a power of two.
    assign wr_addr_s = AW'({frame_r, bin_r});

    // Next-state, counter and write-enable decode for the capture FSM.
    always_comb begin
        state_nxt_s    = state_r;
        bin_nxt_s      = bin_r;
        frame_nxt_s    = frame_r;
        len_err_nxt_s  = len_err_r;
        drop_cnt_nxt_s = drop_cnt_r;
        wr_en_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arm) begin
                    state_nxt_s    = ST_ALIGN;
                    len_err_nxt_s  = 1'b0;
                    drop_cnt_nxt_s = 16'd0;
                    bin_nxt_s      = '0;
                    frame_nxt_s    = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                // Beats are thrown away until the end of a frame is seen.
                if (beat_s && s_axis_tlast) begin
                    state_nxt_s = ST_CAPTURE;
                    bin_nxt_s   = '0;
                    frame_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_ALIGN;
                end
            end
            ST_CAPTURE: begin
                if (!beat_s) begin
                    state_nxt_s = ST_CAPTURE;
                end else if (bin_r == BIN_LAST) begin
                    if (s_axis_tlast) begin
                        wr_en_s   = 1'b1;
                        bin_nxt_s = '0;
                        if (frame_r == FRAME_LAST) begin
                            state_nxt_s = ST_FULL;
                            frame_nxt_s = '0;
                        end else begin
                            frame_nxt_s = frame_r + FW'(1);
                        end
                    end else begin
                        // Missing tlast: framing is lost, so realign from scratch.
                        len_err_nxt_s = 1'b1;
                        state_nxt_s   = ST_ALIGN;
                        bin_nxt_s     = '0;
                        frame_nxt_s   = '0;
                    end
                end else if (s_axis_tlast) begin
                    // Early tlast: drop the partial frame and refill this slot.
                    len_err_nxt_s = 1'b1;
                    bin_nxt_s     = '0;
                end else begin
                    wr_en_s   = 1'b1;
                    bin_nxt_s = bin_r + BW'(1);
                end
            end
            ST_FULL: begin
                if (arm) begin
                    state_nxt_s    = ST_ALIGN;
                    len_err_nxt_s  = 1'b0;
                    drop_cnt_nxt_s = 16'd0;
                end else if (beat_s && (drop_cnt_r != 16'hFFFF)) begin
                    drop_cnt_nxt_s = drop_cnt_r + 16'd1;
                end else begin
                    drop_cnt_nxt_s = drop_cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            bin_r      <= '0;
            frame_r    <= '0;
            len_err_r  <= 1'b0;
            drop_cnt_r <= 16'd0;
            tready_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            bin_r      <= bin_nxt_s;
            frame_r    <= frame_nxt_s;
            len_err_r  <= len_err_nxt_s;
            drop_cnt_r <= drop_cnt_nxt_s;
            tready_r   <= (state_nxt_s != ST_IDLE);
            busy_r     <= (state_nxt_s == ST_ALIGN) || (state_nxt_s == ST_CAPTURE);
            done_r     <= (state_nxt_s == ST_FULL);
        end
    end

    // Capture RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= s_axis_tdata;
        end
    end

    // Registered read port; a same-cycle write is seen only on the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= '0;
        end else begin
            rd_data_r <= mem[rd_addr];
        end
    end

    assign s_axis_tready = tready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign len_err       = len_err_r;
    assign drop_cnt      = drop_cnt_r;
    assign rd_data       = rd_data_r;

endmodule

// File: tb/tb_ospfb_frame_capture.sv
// Scoreboard bench for ospfb_frame_capture: readout expectations are queued
// when an address is issued and checked by a monitor one cycle later.
module tb_ospfb_frame_capture;

    localparam int WIDTH   = 16;
    localparam int FFT_LEN = 64;
    localparam int NFRAMES = 4;
    localparam int AW      = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              arm;
    logic [AW-1:0]     rd_addr;
    logic [31:0]       rd_data;
    logic              busy;
    logic              done;
    logic              len_err;
    logic [15:0]       drop_cnt;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [31:0]       exp_q[$];
    int                addr_q[$];
    bit                rd_req   = 1'b0;
    bit                rd_req_d = 1'b0;

    ospfb_frame_capture #(.WIDTH(WIDTH), .FFT_LEN(FFT_LEN), .NFRAMES(NFRAMES)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .s_axis_tlast(tlast), .arm(arm), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .len_err(len_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Delay the read request to line up with the registered read data.
    always @(posedge clk) rd_req_d <= rd_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int sf, input int b);
        return {16'(b), 16'(sf * 64 + b)};
    endfunction

    // Monitor: pops one expected word for every read the DUT answers.
    always @(negedge clk) begin
        if (rd_req_d) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got %0h expected no read", rd_data);
            end else begin
                check($sformatf("rd_data[%0d]", addr_q.pop_front()), rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic beat(input logic [31:0] d, input logic l, input logic a, input bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        tvalid = 1'b1; tdata = d; tlast = l; arm = a;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0; arm = 1'b0;
    endtask

    task automatic send_part(input int sf, input int b0, input int b1, input bit last_end, input bit gaps);
        for (int b = b0; b <= b1; b++) beat(word(sf, b), (b == b1) && last_end, 1'b0, gaps);
    endtask

    // Last captured frame: done must stay low until its final beat is taken.
    task automatic capture_tail(input int sf, input bit gaps, input logic arm_final);
        send_part(sf, 0, 62, 1'b0, gaps);
        check("done_before_last", 32'(done), 32'd0);
        beat(word(sf, 63), 1'b1, arm_final, gaps);
        check("done_after_last", 32'(done), 32'd1);
        check("busy_after_last", 32'(busy), 32'd0);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic sweep(input int s0, input int s1, input int s2, input int s3);
        int sfs[4];
        sfs = '{s0, s1, s2, s3};
        for (int a = 0; a < 256; a++) begin
            rd_addr = 8'(a);
            rd_req  = 1'b1;
            exp_q.push_back(word(sfs[a / 64], a % 64));
            addr_q.push_back(a);
            @(negedge clk);
        end
        rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rd_q_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tdata = 32'd0; tvalid = 1'b0; tlast = 1'b0; arm = 1'b0; rd_addr = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tready", 32'(tready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);

        // Gapless capture, aligned from bin 10; arm mid-capture must be ignored.
        pulse_arm();
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_tready", 32'(tready), 32'd1);
        send_part(0, 10, 63, 1'b1, 1'b0);
        check("align_busy", 32'(busy), 32'd1);
        send_part(1, 0, 63, 1'b1, 1'b0);
        send_part(2, 0, 9, 1'b0, 1'b0);
        beat(word(2, 10), 1'b0, 1'b1, 1'b0);
        send_part(2, 11, 63, 1'b1, 1'b0);
        send_part(3, 0, 63, 1'b1, 1'b0);
        capture_tail(4, 1'b0, 1'b0);
        check("t1_len_err", 32'(len_err), 32'd0);
        sweep(1, 2, 3, 4);

        // Beats after done are dropped and counted; RAM stays as it was.
        for (int i = 0; i < 300; i++) beat(word(50, i % 64), (i % 64) == 63, 1'b0, 1'b0);
        check("full_drop_cnt", 32'(drop_cnt), 32'd300);
        check("full_done", 32'(done), 32'd1);
        sweep(1, 2, 3, 4);

        // Re-arm, gapped stream with new data; arm on the final beat is ignored.
        pulse_arm();
        check("rearm_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rearm_busy", 32'(busy), 32'd1);
        check("rearm_done", 32'(done), 32'd0);
        send_part(9, 10, 63, 1'b1, 1'b1);
        send_part(10, 0, 63, 1'b1, 1'b1);
        send_part(11, 0, 63, 1'b1, 1'b1);
        send_part(12, 0, 63, 1'b1, 1'b1);
        capture_tail(13, 1'b1, 1'b1);
        beat(word(60, 0), 1'b0, 1'b0, 1'b0);
        check("final_arm_ignored_drop", 32'(drop_cnt), 32'd1);
        check("final_arm_ignored_busy", 32'(busy), 32'd0);
        sweep(10, 11, 12, 13);

        // Early tlast at bin 30 of captured frame 1: that frame is refilled.
        pulse_arm();
        send_part(20, 60, 63, 1'b1, 1'b0);
        send_part(21, 0, 63, 1'b1, 1'b0);
        check("len_err_clean", 32'(len_err), 32'd0);
        send_part(22, 0, 30, 1'b1, 1'b0);
        check("len_err_set", 32'(len_err), 32'd1);
        check("len_err_busy", 32'(busy), 32'd1);
        send_part(23, 0, 63, 1'b1, 1'b0);
        send_part(24, 0, 63, 1'b1, 1'b0);
        capture_tail(25, 1'b0, 1'b0);
        check("len_err_sticky", 32'(len_err), 32'd1);
        sweep(21, 23, 24, 25);

        // Reset at capture beat 100, then a normal capture.
        pulse_arm();
        check("t5_len_err_cleared", 32'(len_err), 32'd0);
        send_part(30, 63, 63, 1'b1, 1'b0);
        send_part(31, 0, 63, 1'b1, 1'b0);
        send_part(32, 0, 35, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_busy_now", 32'(busy), 32'd0);
        check("midrst_tready_now", 32'(tready), 32'd0);
        repeat (3) @(negedge clk);
        check("midrst_rd_data", rd_data, 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_tready", 32'(tready), 32'd0);
        check("postrst_busy", 32'(busy), 32'd0);
        check("postrst_done", 32'(done), 32'd0);
        check("postrst_len_err", 32'(len_err), 32'd0);
        check("postrst_drop_cnt", 32'(drop_cnt), 32'd0);
        pulse_arm();
        send_part(39, 63, 63, 1'b1, 1'b0);
        send_part(40, 0, 63, 1'b1, 1'b0);
        send_part(41, 0, 63, 1'b1, 1'b0);
        send_part(42, 0, 63, 1'b1, 1'b0);
        capture_tail(43, 1'b0, 1'b0);
        check("t5_len_err", 32'(len_err), 32'd0);
        sweep(40, 41, 42, 43);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ospfb_frame_capture.md
Name: ospfb_frame_capture

Overview:
- AXI-Stream sink at the far end of the OSPFB output.
- Aligns to OSPFB frame boundaries using tlast and captures NFRAMES consecutive FFT_LEN-bin complex frames into an internal RAM when armed.
- Exposes the RAM through a synchronous read port for the testbench or host readout.
- Also checks frame length and counts beats dropped while the buffer is full.

Parameters:
- WIDTH, 16: bits per real/imag component; tdata is 2*WIDTH, imag in the upper half.
- FFT_LEN, 64: bins per frame (power of two).
- NFRAMES, 4: frames captured per arm (power of two).
- AW, $clog2(FFT_LEN*NFRAMES): read address width (derived, do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  2*WIDTH  OSPFB output sample {im,re}.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  sink ready.
- s_axis_tlast  in  1  last bin of an OSPFB frame.
- arm  in  1  single-cycle pulse; starts a capture.
- rd_addr  in  AW  readout address, frame*FFT_LEN+bin.
- rd_data  out  2*WIDTH  RAM word at rd_addr, one cycle later.
- busy  out  1  high in ALIGN or CAPTURE.
- done  out  1  high in FULL.
- len_err  out  1  sticky; tlast seen at a bin index other than FFT_LEN-1.
- drop_cnt  out  16  saturating count of beats discarded in FULL.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, s_axis_tready=0, busy=0, done=0, len_err=0, drop_cnt=0, bin/frame counters=0, rd_data=0. RAM contents are not reset.
- Beat definition: a beat is tvalid&&tready. tready is 1 in every state except IDLE, so the sink never back-pressures the OSPFB once armed. In IDLE, tready=0.
- IDLE: arm -> ALIGN, and clears len_err and drop_cnt.
- ALIGN: discards beats until a beat with tlast=1, then -> CAPTURE with bin=0, frame=0. The capture always starts on bin 0 of a frame.
- CAPTURE: each beat writes tdata to RAM[frame*FFT_LEN+bin], then bin++.
  - At bin==FFT_LEN-1: tlast must be 1. Set bin=0 and frame++.
  - When frame==NFRAMES-1 and bin==FFT_LEN-1: -> FULL in the following cycle.
  - tlast=1 with bin!=FFT_LEN-1: set len_err, discard the current partial frame (frame unchanged, bin=0, no further write for this beat), stay in CAPTURE.
  - tlast=0 at bin==FFT_LEN-1: set len_err, go to ALIGN; frame resets to 0.
- FULL: done=1, tready=1. Each beat is dropped and drop_cnt++, saturating at 16'hFFFF.
  - arm -> ALIGN (re-capture, clears drop_cnt and len_err).
- arm while busy is ignored.
- arm in the same cycle as the final capture beat: the beat is written, the state goes to FULL, and arm is ignored.
- Read port: rd_data is registered with one-cycle latency and is valid in any state. Reading an address in the same cycle it is being written returns the old data.
- rst_n asserted mid-capture returns the block to IDLE immediately. done stays 0 until a full new capture completes.
- Address arithmetic: frame*FFT_LEN+bin is a concatenation {frame,bin}; no multiplier.

Test Plan:
- Reset, then arm, then a stream of 5 frames of FFT_LEN=64, tdata={im=bin, re=frame*64+bin}, tlast every 64th beat, starting mid-frame at bin 10 -> 54 beats discarded in ALIGN. RAM[0..255] holds the next 4 full frames in order. done rises one cycle after beat 256 of the capture. len_err=0.
- Same stream with tvalid toggled randomly (50% duty) -> RAM contents identical to the gapless case, and no beat is ever lost.
- tlast injected at bin 30 of captured frame 1 -> len_err=1. That partial frame is discarded. Final RAM frame 1 equals the next clean frame. done is asserted after 4 good frames.
- After done, 300 further beats -> drop_cnt=300, RAM unchanged. A second arm -> drop_cnt=0, busy=1, and a fresh capture overwrites the RAM.
- rst_n pulled low at capture beat 100, held 3 cycles, released -> all outputs at reset values, tready=0. A new arm and capture completes normally.
- Read sweep rd_addr=0..255 after done -> rd_data matches expected at address+1 cycle. Back-to-back addresses produce one word per cycle.
